// File: rtl/register_file_param.sv
// Parametrised register file: two write ports (ALU and load writeback),
// two combinational read ports with optional write-to-read bypass, an
// optional hardwired-zero register 0 and a per-register busy scoreboard
// used by decode for hazard detection.
module register_file_param #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] PW0,
    input  logic [ADDR_W-1:0] RW0,
    input  logic              EN0,
    input  logic [DATA_W-1:0] PW1,
    input  logic [ADDR_W-1:0] RW1,
    input  logic              EN1,
    input  logic [ADDR_W-1:0] RA,
    input  logic [ADDR_W-1:0] RB,
    input  logic              SB_SET,
    input  logic [ADDR_W-1:0] SB_ADDR,
    output logic [DATA_W-1:0] PA,
    output logic [DATA_W-1:0] PB,
    output logic              BUSY_A,
    output logic              BUSY_B,
    output logic              WR_CONFLICT
);

    localparam int DEPTH = 2 ** ADDR_W;

    // Result of one read port: forwarded/stored data plus its busy flag.
    typedef struct packed {
        logic              busy;
        logic [DATA_W-1:0] data;
    } rd_result_t;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;
    logic              wr_conflict_q;
    logic              wr_conflict_d;

    rd_result_t rd_a;
    rd_result_t rd_b;

    // Address 0 is a write/busy sink when it is hardwired to zero.
    function automatic logic is_zero_addr(input logic [ADDR_W-1:0] addr);
        return ZERO_REG && (addr == '0);
    endfunction

    // Next-state of storage, scoreboard and conflict flag from the write ports.
    always_comb begin
        // NOTE: every always_comb output gets a full default first so no path can infer a latch.
        regs_d        = regs_q;
        busy_d        = busy_q;
        wr_conflict_d = EN0 && EN1 && (RW0 == RW1);

        // Port 1 is applied last so it wins a same-address collision.
        if (EN0) begin
            if (!is_zero_addr(RW0)) begin
                regs_d[RW0] = PW0;
            end
            busy_d[RW0] = 1'b0;
        end
        if (EN1) begin
            if (!is_zero_addr(RW1)) begin
                regs_d[RW1] = PW1;
            end
            busy_d[RW1] = 1'b0;
        end

        // Setting after clearing: a newly issued producer keeps the register busy.
        if (SB_SET && !is_zero_addr(SB_ADDR)) begin
            busy_d[SB_ADDR] = 1'b1;
        end
        if (ZERO_REG) begin
            busy_d[0] = 1'b0;
        end
    end

    // State update with synchronous reset taking priority over all writes.
    always_ff @(posedge CLK) begin
        if (RST) begin
            // NOTE: the storage array is reset on purpose; software relies on all registers reading 0 after reset.
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            busy_q        <= '0;
            wr_conflict_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            regs_q        <= regs_d;
            busy_q        <= busy_d;
            wr_conflict_q <= wr_conflict_d;
        end
    end

    // One read port: stored value, overridden by in-flight write data when bypassing.
    function automatic rd_result_t read_port(input logic [ADDR_W-1:0] addr);
        rd_result_t r;
        r.data = regs_q[addr];
        r.busy = busy_q[addr];
        if (BYPASS) begin
            if (EN1 && (RW1 == addr)) begin
                r.data = PW1;
                r.busy = 1'b0;
            end else if (EN0 && (RW0 == addr)) begin
                r.data = PW0;
                r.busy = 1'b0;
            end
        end
        if (is_zero_addr(addr)) begin
            r.data = '0;
            r.busy = 1'b0;
        end
        return r;
    endfunction

    // Combinational read ports A and B.
    always_comb begin
        rd_a = read_port(RA);
        rd_b = read_port(RB);
    end

    assign PA          = rd_a.data;
    assign BUSY_A      = rd_a.busy;
    assign PB          = rd_b.data;
    assign BUSY_B      = rd_b.busy;
    assign WR_CONFLICT = wr_conflict_q;

endmodule

// File: tb/tb_register_file_param.sv
// Directed bench for register_file_param: a default instance (bypass on),
// a BYPASS=0 twin driven by the same stimulus, and a 16-bit/8-entry
// instance with an ordinary register 0.
module tb_register_file_param;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pw0, pw1;
    logic [4:0]  rw0, rw1, ra, rb, sb_addr;
    logic        en0, en1, sb_set;

    logic [31:0] pa, pb, pa_nb, pb_nb;
    logic        busy_a, busy_b, wr_conflict;
    logic        busy_a_nb, busy_b_nb, wr_conflict_nb;

    logic [15:0] s_pw0, s_pw1, s_pa, s_pb;
    logic [2:0]  s_rw0, s_rw1, s_ra, s_rb, s_sb_addr;
    logic        s_en0, s_en1, s_sb_set;
    logic        s_busy_a, s_busy_b, s_wr_conflict;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    register_file_param u_dut (
        .CLK(clk), .RST(rst),
        .PW0(pw0), .RW0(rw0), .EN0(en0),
        .PW1(pw1), .RW1(rw1), .EN1(en1),
        .RA(ra), .RB(rb), .SB_SET(sb_set), .SB_ADDR(sb_addr),
        .PA(pa), .PB(pb), .BUSY_A(busy_a), .BUSY_B(busy_b),
        .WR_CONFLICT(wr_conflict)
    );

    register_file_param #(.BYPASS(1'b0)) u_dut_nb (
        .CLK(clk), .RST(rst),
        .PW0(pw0), .RW0(rw0), .EN0(en0),
        .PW1(pw1), .RW1(rw1), .EN1(en1),
        .RA(ra), .RB(rb), .SB_SET(sb_set), .SB_ADDR(sb_addr),
        .PA(pa_nb), .PB(pb_nb), .BUSY_A(busy_a_nb), .BUSY_B(busy_b_nb),
        .WR_CONFLICT(wr_conflict_nb)
    );

    register_file_param #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1'b0)) u_dut_small (
        .CLK(clk), .RST(rst),
        .PW0(s_pw0), .RW0(s_rw0), .EN0(s_en0),
        .PW1(s_pw1), .RW1(s_rw1), .EN1(s_en1),
        .RA(s_ra), .RB(s_rb), .SB_SET(s_sb_set), .SB_ADDR(s_sb_addr),
        .PA(s_pa), .PB(s_pb), .BUSY_A(s_busy_a), .BUSY_B(s_busy_b),
        .WR_CONFLICT(s_wr_conflict)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drop all write/scoreboard strobes on every instance.
    task automatic idle();
        en0 = 1'b0; en1 = 1'b0; sb_set = 1'b0;
        s_en0 = 1'b0; s_en1 = 1'b0; s_sb_set = 1'b0;
    endtask

    // Advance one edge, then let outputs settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        pw0 = '0; pw1 = '0; rw0 = '0; rw1 = '0; ra = '0; rb = '0; sb_addr = '0;
        s_pw0 = '0; s_pw1 = '0; s_rw0 = '0; s_rw1 = '0; s_ra = '0; s_rb = '0; s_sb_addr = '0;
        idle();
        tick();
        rst = 1'b0;
        ra = 5'd5; rb = 5'd31; #1;
        check("rst_pa", pa, 32'h0);
        check("rst_pb", pb, 32'h0);
        check("rst_busy_a", {31'b0, busy_a}, 32'h0);
        check("rst_conflict", {31'b0, wr_conflict}, 32'h0);

        // Reset discards stored data, a same-cycle write and a same-cycle busy set.
        en0 = 1'b1; rw0 = 5'd5; pw0 = 32'hDEADBEEF;
        tick();
        idle(); #1;
        check("r5_written", pa, 32'hDEADBEEF);
        rst = 1'b1; en0 = 1'b1; rw0 = 5'd6; pw0 = 32'h00001234;
        sb_set = 1'b1; sb_addr = 5'd8;
        tick();
        rst = 1'b0; idle(); ra = 5'd5; rb = 5'd6; #1;
        check("rst_r5", pa, 32'h0);
        check("rst_r6", pb, 32'h0);
        check("rst_conflict2", {31'b0, wr_conflict}, 32'h0);
        ra = 5'd8; #1;
        check("rst_busy8", {31'b0, busy_a}, 32'h0);

        // Register 0 ignores writes and busy sets.
        en0 = 1'b1; rw0 = 5'd0; pw0 = 32'h12345678;
        sb_set = 1'b1; sb_addr = 5'd0; ra = 5'd0; #1;
        check("r0_same_cycle", pa, 32'h0);
        check("r0_busy_same", {31'b0, busy_a}, 32'h0);
        tick();
        idle(); #1;
        check("r0_next", pa, 32'h0);
        check("r0_busy_next", {31'b0, busy_a}, 32'h0);

        // Dual write to r7: port 1 wins, conflict flag for exactly one cycle.
        en0 = 1'b1; rw0 = 5'd7; pw0 = 32'h11111111;
        en1 = 1'b1; rw1 = 5'd7; pw1 = 32'h22222222; ra = 5'd7; #1;
        check("conf_bypass_pa", pa, 32'h22222222);
        check("conf_nb_pa", pa_nb, 32'h0);
        check("conf_before", {31'b0, wr_conflict}, 32'h0);
        tick();
        idle(); #1;
        check("conf_r7", pa, 32'h22222222);
        check("conf_r7_nb", pa_nb, 32'h22222222);
        check("conf_flag", {31'b0, wr_conflict}, 32'h1);
        tick();
        check("conf_flag_drop", {31'b0, wr_conflict}, 32'h0);

        // Dual write to r0 still raises the conflict flag, data stays 0.
        en0 = 1'b1; rw0 = 5'd0; pw0 = 32'hAAAAAAAA;
        en1 = 1'b1; rw1 = 5'd0; pw1 = 32'hBBBBBBBB; ra = 5'd0;
        tick();
        idle(); #1;
        check("conf_r0_flag", {31'b0, wr_conflict}, 32'h1);
        check("conf_r0_data", pa_nb, 32'h0);

        // Bypass of a same-cycle write onto both read ports.
        en0 = 1'b1; rw0 = 5'd3; pw0 = 32'hAAAA0000;
        tick();
        idle();
        en0 = 1'b1; rw0 = 5'd3; pw0 = 32'h0000BBBB; ra = 5'd3; rb = 5'd3; #1;
        check("byp_pa", pa, 32'h0000BBBB);
        check("byp_pb", pb, 32'h0000BBBB);
        check("nb_pa_old", pa_nb, 32'hAAAA0000);
        check("nb_pb_old", pb_nb, 32'hAAAA0000);
        tick();
        idle(); #1;
        check("nb_pa_new", pa_nb, 32'h0000BBBB);

        // Distinct bypass per port: port 1 to RA, port 0 to RB.
        en0 = 1'b1; rw0 = 5'd10; pw0 = 32'h0000000A;
        en1 = 1'b1; rw1 = 5'd11; pw1 = 32'h0000000B; ra = 5'd11; rb = 5'd10; #1;
        check("byp_split_pa", pa, 32'h0000000B);
        check("byp_split_pb", pb, 32'h0000000A);
        tick();
        idle();

        // Scoreboard: busy held while idle, cleared by the writeback.
        sb_set = 1'b1; sb_addr = 5'd9;
        tick();
        idle(); ra = 5'd9; rb = 5'd9;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("sb_busy_a", {31'b0, busy_a}, 32'h1);
            check("sb_busy_b_nb", {31'b0, busy_b_nb}, 32'h1);
            tick();
        end
        en1 = 1'b1; rw1 = 5'd9; pw1 = 32'h5; #1;
        check("sb_wb_busy", {31'b0, busy_a}, 32'h0);
        check("sb_wb_busy_nb", {31'b0, busy_a_nb}, 32'h1);
        check("sb_wb_pa", pa, 32'h5);
        tick();
        idle(); #1;
        check("sb_after_busy", {31'b0, busy_a}, 32'h0);
        check("sb_after_busy_nb", {31'b0, busy_a_nb}, 32'h0);

        // Set/clear collision on r4: data lands, busy stays set.
        sb_set = 1'b1; sb_addr = 5'd4;
        tick();
        sb_set = 1'b1; sb_addr = 5'd4;
        en0 = 1'b1; rw0 = 5'd4; pw0 = 32'h00000044; ra = 5'd4; #1;
        check("coll_busy_fwd", {31'b0, busy_a}, 32'h0);
        tick();
        idle(); #1;
        check("coll_r4", pa, 32'h00000044);
        check("coll_busy", {31'b0, busy_a}, 32'h1);
        check("coll_busy_nb", {31'b0, busy_a_nb}, 32'h1);

        // Small instance: collision at top address 7, ordinary register 0.
        s_sb_set = 1'b1; s_sb_addr = 3'd7;
        tick();
        s_sb_set = 1'b1; s_sb_addr = 3'd7;
        s_en0 = 1'b1; s_rw0 = 3'd7; s_pw0 = 16'h7777;
        tick();
        idle(); s_ra = 3'd7; #1;
        check("small_r7", {16'b0, s_pa}, 32'h00007777);
        check("small_busy7", {31'b0, s_busy_a}, 32'h1);
        s_en1 = 1'b1; s_rw1 = 3'd0; s_pw1 = 16'h00AB;
        s_sb_set = 1'b1; s_sb_addr = 3'd0;
        tick();
        idle(); s_rb = 3'd0; #1;
        check("small_r0", {16'b0, s_pb}, 32'h000000AB);
        check("small_busy0", {31'b0, s_busy_b}, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/register_file_param.md
Name: register_file_param

Overview:
Parametrised successor to the fixed 32x32 register file used by the PPU datapath.
- Depth, data width and R0 zero-hardwiring are configurable.
- Adds a second write port, synchronous reset, optional write-to-read bypass and a per-register busy scoreboard for pipeline hazard detection.
- Sits between the decode stage (read ports, scoreboard set) and the writeback stage (two write ports: ALU result and load result).

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, address width; depth = 2**ADDR_W registers
ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, never busy; 0 = register 0 is an ordinary register
BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads return stored value only

Ports:
CLK  in  1  clock, all state updates on rising edge
RST  in  1  synchronous active-high reset
PW0  in  DATA_W  write data, port 0 (ALU writeback)
RW0  in  ADDR_W  write address, port 0
EN0  in  1  write enable, port 0
PW1  in  DATA_W  write data, port 1 (load writeback)
RW1  in  ADDR_W  write address, port 1
EN1  in  1  write enable, port 1
RA  in  ADDR_W  read address, port A
RB  in  ADDR_W  read address, port B
SB_SET  in  1  mark SB_ADDR busy (instruction issued that will write it)
SB_ADDR  in  ADDR_W  scoreboard target address
PA  out  DATA_W  read data, port A
PB  out  DATA_W  read data, port B
BUSY_A  out  1  register RA has an outstanding write
BUSY_B  out  1  register RB has an outstanding write
WR_CONFLICT  out  1  registered flag: previous cycle had both write ports enabled to the same address

Behaviour:
Reset
- RST=1 at a rising edge clears all registers to 0, all busy bits to 0 and WR_CONFLICT to 0.
- RST takes priority over all writes and SB_SET in that cycle.
- Reset asserted mid-sequence discards pending busy state. No recovery of lost writes.
- After reset, PA=PB=0 and BUSY_A=BUSY_B=0 for any address.

Write (rising edge, RST=0)
- ENn=1 stores PWn into register RWn.
- EN0 and EN1 both set with RW0==RW1: port 1 wins. WR_CONFLICT=1 for the next cycle only, otherwise 0.
- ZERO_REG=1: writes to address 0 are dropped on both ports. They still count for WR_CONFLICT.
- Write latency is 1 cycle. The stored value is visible through the non-bypass path from the next cycle.

Read (combinational, zero latency)
- Default: PA = reg[RA], PB = reg[RB].
- BYPASS=1, in priority order:
  - EN1 and RW1==RA: PA = PW1.
  - Else EN0 and RW0==RA: PA = PW0.
  - Same rules for PB/RB.
- ZERO_REG=1 and RA==0: PA = 0 regardless of bypass. Same for PB/RB.
- Both read ports may address the same register simultaneously.

Scoreboard (busy[2**ADDR_W])
- Rising edge, SB_SET=1: busy[SB_ADDR] <= 1.
- Rising edge, any enabled write to address X: busy[X] <= 0.
- SB_SET and a write to the same address in the same cycle: set wins, because a new producer is in flight. busy stays 1.
- ZERO_REG=1: busy[0] is always 0 and SB_SET to address 0 is ignored.
- BUSY_A = busy[RA], except with BYPASS=1 it is forced to 0 when an enabled write hits RA this cycle (data is forwarded). BUSY_B is the same for RB.
- BYPASS=0: BUSY_A stays asserted through the writeback cycle and drops the cycle after.

Test Plan:
- Reset: write 0xDEADBEEF to r5, assert RST with EN0=1 to r6 -> next cycle r5=r6=0, all BUSY=0, WR_CONFLICT=0.
- Zero register (ZERO_REG=1): EN0 write 0x12345678 to r0, SB_SET r0 -> PA(RA=0)=0 same and next cycle, BUSY_A=0.
- Dual-write conflict: EN0 r7=0x11111111, EN1 r7=0x22222222 same edge -> r7=0x22222222, WR_CONFLICT=1 for exactly one cycle.
- Bypass (BYPASS=1): r3 holds 0xAAAA0000, EN0 r3=0x0000BBBB with RA=RB=3 -> PA=PB=0x0000BBBB the same cycle. With BYPASS=0 -> PA=0xAAAA0000 until the edge.
- Scoreboard: SB_SET r9, then RA=9 for 3 idle cycles -> BUSY_A=1. EN1 r9=0x5 -> BUSY_A=0 in that cycle (BYPASS=1) and busy[9]=0 after.
- Set/clear collision: busy r4 set, then same-edge SB_SET r4 and EN0 write r4 -> r4 updated, busy[4] remains 1. Repeat at DATA_W=16, ADDR_W=3 to confirm 8-entry wrap (address 7 max).
